// File: rtl/ioq_hdr_inserter.sv
// ioq_hdr_inserter
// Store-and-forward ingress stage: buffers each raw packet, measures its
// word and byte length, then emits an IOQ module header followed by the
// unchanged packet words.
//
// Ports
//   clk, reset      datapath clock, synchronous active-high reset
//   in_data/in_ctrl raw packet word; in_ctrl != 0 marks EOP (one-hot byte marker)
//   in_wr, in_rdy   input write strobe / upstream may write
//   src_port_cfg    one-hot source port, captured on the first word of a packet
//   out_data/ctrl   output word (header word carries ctrl = IOQ_HDR_CTRL)
//   out_wr, out_rdy output word valid / downstream can accept
//   pkts_sent       packets fully emitted, wraps
//
// Output FSM
//   state    | meaning
//   OUT_IDLE | no complete packet queued
//   OUT_HDR  | header queued, waiting for out_rdy to emit it
//   OUT_BODY | streaming packet words until the EOP word is emitted
module ioq_hdr_inserter #(
    parameter int                    DATA_WIDTH           = 64,
    parameter int                    CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter int                    DATA_FIFO_DEPTH_BITS = 9,
    parameter int                    HDR_FIFO_DEPTH_BITS  = 3,
    parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL         = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [15:0]           src_port_cfg,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkts_sent
);

    localparam int DDEPTH = 1 << DATA_FIFO_DEPTH_BITS;
    localparam int HDEPTH = 1 << HDR_FIFO_DEPTH_BITS;
    localparam int DW     = CTRL_WIDTH + DATA_WIDTH;
    localparam int HW     = 48;

    localparam logic [DATA_FIFO_DEPTH_BITS:0] D_NF_LEVEL = (DATA_FIFO_DEPTH_BITS + 1)'(DDEPTH - 2);
    localparam logic [HDR_FIFO_DEPTH_BITS:0]  H_LAST     = (HDR_FIFO_DEPTH_BITS + 1)'(HDEPTH - 1);

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HDR,
        OUT_BODY
    } out_state_t;

    // ------------------------------------------------------------------
    // Packet data FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]                 dmem [DDEPTH];
    logic [DATA_FIFO_DEPTH_BITS:0] d_wptr, d_rptr, d_count;
    logic [DW-1:0]                 d_rdata;
    logic                          data_empty, data_full, data_nearly_full;
    logic                          data_wr, data_pop;

    assign d_count          = d_wptr - d_rptr;
    assign data_empty       = (d_count == '0);
    assign data_full        = d_count[DATA_FIFO_DEPTH_BITS];
    assign data_nearly_full = (d_count >= D_NF_LEVEL);
    assign d_rdata          = dmem[d_rptr[DATA_FIFO_DEPTH_BITS-1:0]];
    assign data_wr          = in_wr && !reset && !data_full;

    always_ff @(posedge clk) begin
        if (data_wr)
            dmem[d_wptr[DATA_FIFO_DEPTH_BITS-1:0]] <= {in_ctrl, in_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_wptr <= '0;
            d_rptr <= '0;
        end else begin
            if (data_wr)
                d_wptr <= d_wptr + 1'b1;
            if (data_pop)
                d_rptr <= d_rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending-header FIFO: {word_len, src_port, byte_len}
    // ------------------------------------------------------------------
    logic [HW-1:0]                hmem [HDEPTH];
    logic [HDR_FIFO_DEPTH_BITS:0] h_wptr, h_rptr, h_count;
    logic [HW-1:0]                h_rdata;
    logic                         hdr_empty, hdr_fifo_full, hdr_full;
    logic                         hdr_push, hdr_pop;
    logic                         pend_vld;
    logic [HW-1:0]                pend_hdr;

    assign h_count       = h_wptr - h_rptr;
    assign hdr_empty     = (h_count == '0);
    assign hdr_fifo_full = h_count[HDR_FIFO_DEPTH_BITS];
    assign h_rdata       = hmem[h_rptr[HDR_FIFO_DEPTH_BITS-1:0]];
    assign hdr_push      = pend_vld && !hdr_fifo_full;

    // The header of a just-finished packet is still in the pending register
    // for one cycle, so it must count against the header capacity.
    assign hdr_full = hdr_fifo_full || (pend_vld && h_count == H_LAST);
    assign in_rdy   = !data_nearly_full && !hdr_full;

    always_ff @(posedge clk) begin
        if (hdr_push)
            hmem[h_wptr[HDR_FIFO_DEPTH_BITS-1:0]] <= pend_hdr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_wptr <= '0;
            h_rptr <= '0;
        end else begin
            if (hdr_push)
                h_wptr <= h_wptr + 1'b1;
            if (hdr_pop)
                h_rptr <= h_rptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Packet length tracking
    // ------------------------------------------------------------------
    logic [15:0] word_cnt;
    logic [15:0] src_lat;
    logic [15:0] src_cur;
    logic [15:0] word_len;
    logic [15:0] byte_len;
    logic [3:0]  eop_bytes;

    // Lowest set ctrl bit k gives 8-k valid bytes in the EOP word.
    always_comb begin
        eop_bytes = 4'd0;
        for (int i = CTRL_WIDTH - 1; i >= 0; i--) begin
            if (in_ctrl[i])
                eop_bytes = 4'(CTRL_WIDTH - i);
        end
    end

    // A single-word packet has no earlier cycle to latch the source port.
    assign src_cur  = (word_cnt == 16'd0) ? src_port_cfg : src_lat;
    assign word_len = word_cnt + 16'd1;
    assign byte_len = {word_cnt[12:0], 3'b000} + {12'd0, eop_bytes};

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
            src_lat  <= '0;
            pend_vld <= 1'b0;
            pend_hdr <= '0;
        end else begin
            pend_vld <= 1'b0;
            if (data_wr) begin
                if (word_cnt == 16'd0)
                    src_lat <= src_port_cfg;
                if (|in_ctrl) begin
                    pend_vld <= 1'b1;
                    pend_hdr <= {word_len, src_cur, byte_len};
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM, outputs registered from next-state logic
    // ------------------------------------------------------------------
    out_state_t            state, state_nxt;
    logic                  out_wr_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [CTRL_WIDTH-1:0] out_ctrl_nxt;
    logic                  pkt_done;

    always_comb begin
        state_nxt    = state;
        out_wr_nxt   = 1'b0;
        out_data_nxt = out_data;
        out_ctrl_nxt = out_ctrl;
        hdr_pop      = 1'b0;
        data_pop     = 1'b0;
        pkt_done     = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (!hdr_empty)
                    state_nxt = OUT_HDR;
            end
            OUT_HDR: begin
                if (out_rdy && !hdr_empty) begin
                    hdr_pop      = 1'b1;
                    out_wr_nxt   = 1'b1;
                    out_data_nxt = {{(DATA_WIDTH - HW){1'b0}}, h_rdata};
                    out_ctrl_nxt = IOQ_HDR_CTRL;
                    state_nxt    = OUT_BODY;
                end
            end
            OUT_BODY: begin
                if (out_rdy && !data_empty) begin
                    data_pop     = 1'b1;
                    out_wr_nxt   = 1'b1;
                    out_data_nxt = d_rdata[DATA_WIDTH-1:0];
                    out_ctrl_nxt = d_rdata[DW-1:DATA_WIDTH];
                    if (|d_rdata[DW-1:DATA_WIDTH]) begin
                        pkt_done  = 1'b1;
                        state_nxt = hdr_empty ? OUT_IDLE : OUT_HDR;
                    end
                end
            end
            default: state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OUT_IDLE;
            out_wr    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            pkts_sent <= '0;
        end else begin
            state    <= state_nxt;
            out_wr   <= out_wr_nxt;
            out_data <= out_data_nxt;
            out_ctrl <= out_ctrl_nxt;
            if (pkt_done)
                pkts_sent <= pkts_sent + 32'd1;
        end
    end

endmodule
